// File: rtl/post_accumulator.sv
// post_accumulator
//   Two-stage DSP-style post-adder/accumulator.
//   Stage 1 registers every operand, the opmode fields and in_valid.
//   Stage 2 selects X and Z, then forms Z + X + cin or Z - X - cin into
//   {carryout, p}. P is fed back so that the block can accumulate.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides ce
//   ce           clock enable for every register
//   in_valid     operands/opmode valid this cycle
//   m_in         multiplier product, zero-extended to WIDTH
//   dab_in       concatenated D:A:B operand
//   c_in         C operand
//   pcin         cascade input from the previous slice
//   cin          post-adder carry-in
//   opmode_x     X select: 0 zero, 1 M, 2 P, 3 D:A:B
//   opmode_z     Z select: 0 zero, 1 PCIN, 2 P, 3 C
//   opmode_sub   0 add, 1 subtract
//   p            registered result
//   pcout        cascade output, identical to p
//   carryout     registered carry (add) or borrow (subtract)
//   out_valid    p/carryout were updated by a valid operation
module post_accumulator #(
    parameter int unsigned WIDTH  = 48,
    parameter int unsigned MWIDTH = 36  // must be smaller than WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [MWIDTH-1:0] m_in,
    input  logic [WIDTH-1:0]  dab_in,
    input  logic [WIDTH-1:0]  c_in,
    input  logic [WIDTH-1:0]  pcin,
    input  logic              cin,
    input  logic [1:0]        opmode_x,
    input  logic [1:0]        opmode_z,
    input  logic              opmode_sub,
    output logic [WIDTH-1:0]  p,
    output logic [WIDTH-1:0]  pcout,
    output logic              carryout,
    output logic              out_valid
);

    localparam logic [1:0] XSelZero = 2'd0;
    localparam logic [1:0] XSelM    = 2'd1;
    localparam logic [1:0] XSelP    = 2'd2;
    localparam logic [1:0] XSelDab  = 2'd3;

    localparam logic [1:0] ZSelZero = 2'd0;
    localparam logic [1:0] ZSelPcin = 2'd1;
    localparam logic [1:0] ZSelP    = 2'd2;
    localparam logic [1:0] ZSelC    = 2'd3;

    // ------------------------------------------------------------------
    // Stage 1: operand / opmode registers
    // ------------------------------------------------------------------
    logic [MWIDTH-1:0] m_q,      m_d;
    logic [WIDTH-1:0]  dab_q,    dab_d;
    logic [WIDTH-1:0]  c_q,      c_d;
    logic [WIDTH-1:0]  pcin_q,   pcin_d;
    logic              cin_q,    cin_d;
    logic [1:0]        opx_q,    opx_d;
    logic [1:0]        opz_q,    opz_d;
    logic              sub_q,    sub_d;
    logic              vld_q,    vld_d;

    always_comb begin
        m_d    = m_q;
        dab_d  = dab_q;
        c_d    = c_q;
        pcin_d = pcin_q;
        cin_d  = cin_q;
        opx_d  = opx_q;
        opz_d  = opz_q;
        sub_d  = sub_q;
        vld_d  = vld_q;
        if (ce) begin
            m_d    = m_in;
            dab_d  = dab_in;
            c_d    = c_in;
            pcin_d = pcin;
            cin_d  = cin;
            opx_d  = opmode_x;
            opz_d  = opmode_z;
            sub_d  = opmode_sub;
            vld_d  = in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q    <= '0;
            dab_q  <= '0;
            c_q    <= '0;
            pcin_q <= '0;
            cin_q  <= 1'b0;
            opx_q  <= 2'd0;
            opz_q  <= 2'd0;
            sub_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            m_q    <= m_d;
            dab_q  <= dab_d;
            c_q    <= c_d;
            pcin_q <= pcin_d;
            cin_q  <= cin_d;
            opx_q  <= opx_d;
            opz_q  <= opz_d;
            sub_q  <= sub_d;
            vld_q  <= vld_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: operand select and post-adder
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p_q, p_d;
    logic             co_q, co_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] x_val;
    logic [WIDTH-1:0] z_val;
    logic [WIDTH:0]   sum;

    always_comb begin
        x_val = '0;
        unique case (opx_q)
            XSelZero: x_val = '0;
            XSelM:    x_val = {{(WIDTH - MWIDTH){1'b0}}, m_q};
            XSelP:    x_val = p_q;
            XSelDab:  x_val = dab_q;
            default:  x_val = '0;
        endcase
    end

    always_comb begin
        z_val = '0;
        unique case (opz_q)
            ZSelZero: z_val = '0;
            ZSelPcin: z_val = pcin_q;
            ZSelP:    z_val = p_q;
            ZSelC:    z_val = c_q;
            default:  z_val = '0;
        endcase
    end

    // One extra bit holds the carry on add and the borrow on subtract.
    always_comb begin
        if (sub_q) begin
            sum = {1'b0, z_val} - {1'b0, x_val} - {{WIDTH{1'b0}}, cin_q};
        end else begin
            sum = {1'b0, z_val} + {1'b0, x_val} + {{WIDTH{1'b0}}, cin_q};
        end
    end

    always_comb begin
        p_d         = p_q;
        co_d        = co_q;
        out_valid_d = out_valid_q;
        if (ce) begin
            out_valid_d = vld_q;
            // Invalid slots leave the accumulator untouched.
            if (vld_q) begin
                p_d  = sum[WIDTH-1:0];
                co_d = sum[WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q         <= '0;
            co_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            co_q        <= co_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign pcout     = p_q;
    assign carryout  = co_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/post_accumulator.md
POST_ACCUMULATOR -- requirements
Module: post_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 48, meaning post-adder, C, D:A:B, PCIN and P width.
REQ-002 SHALL have parameter MWIDTH, default 36, meaning multiplier product width; MWIDTH < WIDTH.
REQ-003 SHALL have port clk  input  1  rising-edge clock; single clock domain.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ce  input  1  clock enable for all internal registers.
REQ-006 SHALL have port in_valid  input  1  operands and opmode valid this cycle.
REQ-007 SHALL have port m_in  input  MWIDTH  multiplier product, zero-extended to WIDTH when used.
REQ-008 SHALL have port dab_in  input  WIDTH  concatenated D:A:B operand.
REQ-009 SHALL have port c_in  input  WIDTH  C operand.
REQ-010 SHALL have port pcin  input  WIDTH  cascade input from the previous slice.
REQ-011 SHALL have port cin  input  1  carry-in to the post-adder.
REQ-012 SHALL have port opmode_x  input  2  X select: 0 zero, 1 M, 2 P, 3 D:A:B.
REQ-013 SHALL have port opmode_z  input  2  Z select: 0 zero, 1 PCIN, 2 P, 3 C.
REQ-014 SHALL have port opmode_sub  input  1  0 add, 1 subtract.
REQ-015 SHALL have port p  output  WIDTH  registered post-adder result.
REQ-016 SHALL have port pcout  output  WIDTH  cascade output, always equal to p.
REQ-017 SHALL have port carryout  output  1  registered carry/borrow.
REQ-018 SHALL have port out_valid  output  1  p/carryout updated by a valid operation.

Function
REQ-019 Stage 1 SHALL register m_in, dab_in, c_in, pcin, cin, opmode_x, opmode_z, opmode_sub and in_valid on each clk edge with ce=1.
REQ-020 Stage 2 SHALL compute from stage-1 registers, with P being the current p register value.
REQ-021 Add: {carryout,p} SHALL be the (WIDTH+1)-bit result Z + X + cin.
REQ-022 Subtract: {carryout,p} SHALL be the (WIDTH+1)-bit result Z - X - cin, carryout being bit WIDTH (borrow); wrap-around modulo 2^WIDTH, no saturation.
REQ-023 p and carryout SHALL load only on a ce=1 edge when stage-1 valid=1; otherwise they hold.
REQ-024 out_valid SHALL load stage-1 valid on every ce=1 edge, giving latency 2 enabled cycles from in_valid to out_valid.
REQ-025 With ce=0 every register (both stages, out_valid included) SHALL hold its value.
REQ-026 Selecting P for both X and Z SHALL use the same p value (p doubles when adding, zero with cin=0 when subtracting).
REQ-027 Back-to-back in_valid SHALL give one result per cycle; accumulation (X or Z = P) SHALL see the result of the immediately preceding valid operation.
REQ-028 Invalid cycles between valid operations SHALL not disturb p; accumulation resumes from the held value.

Reset
REQ-029 rst=1 on a clk edge SHALL clear all stage-1 registers, p, carryout and out_valid to 0, regardless of ce.
REQ-030 rst SHALL take priority over ce and in_valid; an operation in flight when rst asserts SHALL be discarded, with no output after release.
REQ-031 First in_valid accepted after rst deasserts SHALL yield out_valid two enabled edges later.

Verification
REQ-032 Reset then in_valid=1 with x=M, z=C, add, m_in=5, c_in=10, cin=1 -> after 2 edges p=16, carryout=0, out_valid=1.
REQ-033 Accumulate: x=M, z=P, add, m_in=3 on 4 consecutive cycles from p=0 -> p=3,6,9,12 on successive cycles, out_valid held at 1.
REQ-034 Subtract wrap: x=D:A:B=1, z=zero, sub, cin=0 -> p=all ones (0xFFFF_FFFF_FFFF), carryout=1.
REQ-035 Add overflow: z=C=0xFFFF_FFFF_FFFF, x=zero, cin=1 -> p=0, carryout=1.
REQ-036 ce low for 3 cycles mid-stream -> p, carryout, out_valid frozen; stream resumes without loss or duplication when ce returns to 1.
REQ-037 rst asserted the cycle after in_valid -> p=0, out_valid=0, and no result appears after release.
